// File: rtl/ice40_io_pkg.sv
// ice40_io_pkg: PIN_TYPE field encodings shared by the I/O cell and its register pair
package ice40_io_pkg;
    localparam logic [3:0] PIN_OUTPUT_NONE       = 4'b0000;
    localparam logic [3:0] PIN_OUTPUT_TRISTATE   = 4'b1010;
    localparam logic [3:0] PIN_OUTPUT_REGISTERED = 4'b0101;
    localparam logic [3:0] PIN_OUTPUT_DDR        = 4'b0100;

    localparam logic [1:0] PIN_INPUT                  = 2'b01;
    localparam logic [1:0] PIN_INPUT_REGISTERED       = 2'b00;
    localparam logic [1:0] PIN_INPUT_LATCH            = 2'b11;
    localparam logic [1:0] PIN_INPUT_REGISTERED_LATCH = 2'b10;

    // PIN_TYPE[5:4] drive control and PIN_TYPE[3:2] output data source
    localparam logic [1:0] EN_NEVER    = PIN_OUTPUT_NONE[3:2];
    localparam logic [1:0] EN_ALWAYS   = PIN_OUTPUT_REGISTERED[3:2];
    localparam logic [1:0] EN_COMB     = PIN_OUTPUT_TRISTATE[3:2];
    localparam logic [1:0] EN_REG      = 2'b11;
    localparam logic [1:0] OUT_DDR     = PIN_OUTPUT_DDR[1:0];
    localparam logic [1:0] OUT_REG     = PIN_OUTPUT_REGISTERED[1:0];
    localparam logic [1:0] OUT_COMB    = PIN_OUTPUT_TRISTATE[1:0];
    localparam logic [1:0] OUT_REG_INV = 2'b11;
endpackage

// File: rtl/ice40_io_ddr_reg.sv
// ice40_io_ddr_reg: rising/falling-edge register pair with clock enable and async active-low clear
module ice40_io_ddr_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic d_rise,
    input  logic d_fall,
    output logic rise_q,
    output logic fall_q
);
    logic rise_d, fall_d;

    always_comb begin
        rise_d = ce ? d_rise : rise_q;
        fall_d = ce ? d_fall : fall_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rise_q <= 1'b0;
        else rise_q <= rise_d;

    always_ff @(negedge clk or negedge rst_n)
        if (!rst_n) fall_q <= 1'b0;
        else fall_q <= fall_d;
endmodule

// File: rtl/ice40_io_cell.sv
// ice40_io_cell: bidirectional pin with combinational, registered or DDR output, enable and input paths
module ice40_io_cell
    import ice40_io_pkg::*;
#(
    parameter logic [5:0] PIN_TYPE = 6'b1010_01,
    parameter logic       PULLUP   = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLOCK_ENABLE,
    inout  wire  PACKAGE_PIN,
    input  logic OUTPUT_ENABLE,
    input  logic D_OUT_0,
    input  logic D_OUT_1,
    input  logic LATCH_INPUT_VALUE,
    output logic D_IN_0,
    output logic D_IN_1
);
    localparam logic [1:0] EN_MODE  = PIN_TYPE[5:4];
    localparam logic [1:0] OUT_MODE = PIN_TYPE[3:2];
    localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];
    localparam logic       IS_LATCH = IN_MODE == PIN_INPUT_LATCH || IN_MODE == PIN_INPUT_REGISTERED_LATCH;
    localparam logic       IS_DIRECT = IN_MODE == PIN_INPUT || IN_MODE == PIN_INPUT_LATCH;

    logic dout_q0, dout_q1, din_q0, din_q1;
    logic oe_d, oe_q, din_latch_d, din_latch_q;
    logic pin_in, pin_out, pin_oe, din_src;

    assign pin_in = PACKAGE_PIN;

    ice40_io_ddr_reg u_out (
        .clk(CLK), .rst_n(RST), .ce(CLOCK_ENABLE),
        .d_rise(D_OUT_0), .d_fall(D_OUT_1), .rise_q(dout_q0), .fall_q(dout_q1)
    );

    // input side samples the pin even while this cell drives it
    ice40_io_ddr_reg u_in (
        .clk(CLK), .rst_n(RST), .ce(CLOCK_ENABLE),
        .d_rise(pin_in), .d_fall(pin_in), .rise_q(din_q0), .fall_q(din_q1)
    );

    always_comb begin
        oe_d        = CLOCK_ENABLE ? OUTPUT_ENABLE : oe_q;
        din_latch_d = (CLOCK_ENABLE && !LATCH_INPUT_VALUE) ? pin_in : din_latch_q;
        pin_out     = OUT_MODE == OUT_DDR  ? (CLK ? dout_q0 : dout_q1) :
                      OUT_MODE == OUT_REG  ? dout_q0 :
                      OUT_MODE == OUT_COMB ? D_OUT_0 : ~dout_q0;
        pin_oe      = EN_MODE == EN_ALWAYS ||
                      (EN_MODE == EN_COMB && OUTPUT_ENABLE) ||
                      (EN_MODE == EN_REG && oe_q);
        din_src     = IS_DIRECT ? pin_in : din_q0;
        D_IN_0      = (IS_LATCH && LATCH_INPUT_VALUE) ? din_latch_q : din_src;
    end

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            oe_q        <= 1'b0;
            din_latch_q <= 1'b0;
        end else begin
            oe_q        <= oe_d;
            din_latch_q <= din_latch_d;
        end

    assign PACKAGE_PIN = pin_oe ? pin_out : 1'bz;
    assign D_IN_1      = din_q1;

    generate
        if (PULLUP && EN_MODE != EN_ALWAYS) begin : g_pullup
            pullup pu (PACKAGE_PIN);
        end
    endgenerate
endmodule

// File: tb/tb_ice40_io_cell.sv
// tb_ice40_io_cell: directed and randomized checks of several PIN_TYPE variants against a behavioural model
module tb_ice40_io_cell;
    logic clk = 1'b0, rst_n = 1'b0, ce = 1'b1, oe = 1'b0, d0 = 1'b0, d1 = 1'b0, latch = 1'b0;
    logic tri_v = 1'b1, lat_v = 1'b0, rl_v = 1'b0;
    logic [6:0] di0, di1;
    int checks = 0, errors = 0;
    wire p_tri, p_reg, p_ddr, p_oer, p_lat, p_pu, p_rl;

    assign p_tri = oe ? 1'bz : tri_v;
    assign p_lat = lat_v;
    assign p_rl  = rl_v;

    always #5 clk = ~clk;

    ice40_io_cell #(.PIN_TYPE(6'b1010_01), .PULLUP(1'b0)) u_tri (.CLK(clk), .RST(rst_n), .CLOCK_ENABLE(ce),
        .PACKAGE_PIN(p_tri), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1), .LATCH_INPUT_VALUE(latch), .D_IN_0(di0[0]), .D_IN_1(di1[0]));
    ice40_io_cell #(.PIN_TYPE(6'b0101_00), .PULLUP(1'b0)) u_reg (.CLK(clk), .RST(rst_n), .CLOCK_ENABLE(ce),
        .PACKAGE_PIN(p_reg), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1), .LATCH_INPUT_VALUE(latch), .D_IN_0(di0[1]), .D_IN_1(di1[1]));
    ice40_io_cell #(.PIN_TYPE(6'b0100_00), .PULLUP(1'b0)) u_ddr (.CLK(clk), .RST(rst_n), .CLOCK_ENABLE(ce),
        .PACKAGE_PIN(p_ddr), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1), .LATCH_INPUT_VALUE(latch), .D_IN_0(di0[2]), .D_IN_1(di1[2]));
    ice40_io_cell #(.PIN_TYPE(6'b1110_01), .PULLUP(1'b1)) u_oer (.CLK(clk), .RST(rst_n), .CLOCK_ENABLE(ce),
        .PACKAGE_PIN(p_oer), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1), .LATCH_INPUT_VALUE(latch), .D_IN_0(di0[3]), .D_IN_1(di1[3]));
    ice40_io_cell #(.PIN_TYPE(6'b0000_11), .PULLUP(1'b0)) u_lat (.CLK(clk), .RST(rst_n), .CLOCK_ENABLE(ce),
        .PACKAGE_PIN(p_lat), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1), .LATCH_INPUT_VALUE(latch), .D_IN_0(di0[4]), .D_IN_1(di1[4]));
    ice40_io_cell #(.PIN_TYPE(6'b0000_01), .PULLUP(1'b1)) u_pu (.CLK(clk), .RST(rst_n), .CLOCK_ENABLE(ce),
        .PACKAGE_PIN(p_pu), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1), .LATCH_INPUT_VALUE(latch), .D_IN_0(di0[5]), .D_IN_1(di1[5]));
    ice40_io_cell #(.PIN_TYPE(6'b0000_10), .PULLUP(1'b0)) u_rl (.CLK(clk), .RST(rst_n), .CLOCK_ENABLE(ce),
        .PACKAGE_PIN(p_rl), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1), .LATCH_INPUT_VALUE(latch), .D_IN_0(di0[6]), .D_IN_1(di1[6]));

    task automatic at_pos; @(posedge clk); #1; endtask
    task automatic at_neg; @(negedge clk); #1; endtask

    task automatic test_reset;
        #2;
        checks += 8;
        if (p_reg !== 1'b0) begin errors++; $display("FAIL reset_reg_pin got %b exp 0", p_reg); end
        if (di0[1] !== 1'b0) begin errors++; $display("FAIL reset_reg_din0 got %b exp 0", di0[1]); end
        if (p_ddr !== 1'b0) begin errors++; $display("FAIL reset_ddr_pin got %b exp 0", p_ddr); end
        if (di1[2] !== 1'b0) begin errors++; $display("FAIL reset_ddr_din1 got %b exp 0", di1[2]); end
        if (p_oer !== 1'b1) begin errors++; $display("FAIL reset_oer_released got %b exp 1", p_oer); end
        if (di0[0] !== 1'b1) begin errors++; $display("FAIL reset_tri_din0_follows_pin got %b exp 1", di0[0]); end
        if (di0[6] !== 1'b0) begin errors++; $display("FAIL reset_rlatch_din0 got %b exp 0", di0[6]); end
        if (di0[5] !== 1'b1) begin errors++; $display("FAIL pullup_din0 got %b exp 1", di0[5]); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_comb_tristate;
        at_neg;
        oe = 1'b1; d0 = 1'b1;
        #1 checks += 2;
        if (p_tri !== 1'b1) begin errors++; $display("FAIL tri_drive1 got %b exp 1", p_tri); end
        if (di0[0] !== 1'b1) begin errors++; $display("FAIL tri_loopback1 got %b exp 1", di0[0]); end
        d0 = 1'b0;
        #1 checks++;
        if (p_tri !== 1'b0) begin errors++; $display("FAIL tri_drive0 got %b exp 0", p_tri); end
        oe = 1'b0; d0 = 1'b1; tri_v = 1'b0;
        #1 checks += 2;
        if (p_tri !== 1'b0) begin errors++; $display("FAIL tri_ext0_pin got %b exp 0", p_tri); end
        if (di0[0] !== 1'b0) begin errors++; $display("FAIL tri_ext0_din0 got %b exp 0", di0[0]); end
        tri_v = 1'b1;
        #1 checks++;
        if (di0[0] !== 1'b1) begin errors++; $display("FAIL tri_ext1_din0 got %b exp 1", di0[0]); end
    endtask

    task automatic test_registered;
        d0 = 1'b0;
        at_pos; at_neg;
        d0 = 1'b1;
        #1 checks++;
        if (p_reg !== 1'b0) begin errors++; $display("FAIL reg_before_edge got %b exp 0", p_reg); end
        at_pos; checks += 2;
        if (p_reg !== 1'b1) begin errors++; $display("FAIL reg_after_edge1 got %b exp 1", p_reg); end
        if (di0[1] !== 1'b0) begin errors++; $display("FAIL reg_din0_prev got %b exp 0", di0[1]); end
        at_neg; d0 = 1'b0;
        at_pos; checks += 2;
        if (p_reg !== 1'b0) begin errors++; $display("FAIL reg_after_edge2 got %b exp 0", p_reg); end
        if (di0[1] !== 1'b1) begin errors++; $display("FAIL reg_din0_loop got %b exp 1", di0[1]); end
    endtask

    task automatic test_ddr;
        at_neg; d0 = 1'b1; d1 = 1'b0; lat_v = 1'b1;
        at_pos; at_neg; checks++;
        if (di1[4] !== 1'b1) begin errors++; $display("FAIL din1_negedge_capture got %b exp 1", di1[4]); end
        lat_v = 1'b0;
        at_pos; checks += 2;
        if (p_ddr !== 1'b1) begin errors++; $display("FAIL ddr_high_phase got %b exp 1", p_ddr); end
        if (di1[4] !== 1'b1) begin errors++; $display("FAIL din1_hold_high got %b exp 1", di1[4]); end
        at_neg; checks += 2;
        if (p_ddr !== 1'b0) begin errors++; $display("FAIL ddr_low_phase got %b exp 0", p_ddr); end
        if (di1[4] !== 1'b0) begin errors++; $display("FAIL din1_negedge_capture0 got %b exp 0", di1[4]); end
        d0 = 1'b0; d1 = 1'b1;
        at_pos; checks++;
        if (p_ddr !== 1'b0) begin errors++; $display("FAIL ddr_high_swap got %b exp 0", p_ddr); end
        at_neg; checks++;
        if (p_ddr !== 1'b1) begin errors++; $display("FAIL ddr_low_swap got %b exp 1", p_ddr); end
    endtask

    task automatic test_oe_registered;
        d0 = 1'b0; oe = 1'b0;
        at_pos; at_neg;
        oe = 1'b1;
        #1 checks++;
        if (p_oer !== 1'b1) begin errors++; $display("FAIL oer_still_released got %b exp 1", p_oer); end
        at_pos; checks += 2;
        if (p_oer !== 1'b0) begin errors++; $display("FAIL oer_driven_after_edge got %b exp 0", p_oer); end
        if (di0[3] !== 1'b0) begin errors++; $display("FAIL oer_din0 got %b exp 0", di0[3]); end
        at_neg; oe = 1'b0;
        #1 checks++;
        if (p_oer !== 1'b0) begin errors++; $display("FAIL oer_still_driven got %b exp 0", p_oer); end
        at_pos; checks++;
        if (p_oer !== 1'b1) begin errors++; $display("FAIL oer_released_after_edge got %b exp 1", p_oer); end
    endtask

    task automatic test_latch;
        at_neg; latch = 1'b0; lat_v = 1'b1;
        at_pos; at_neg;
        latch = 1'b1;
        #1 lat_v = 1'b0;
        #1 checks++;
        if (di0[4] !== 1'b1) begin errors++; $display("FAIL latch_hold got %b exp 1", di0[4]); end
        at_pos; checks++;
        if (di0[4] !== 1'b1) begin errors++; $display("FAIL latch_hold_edge got %b exp 1", di0[4]); end
        at_neg; latch = 1'b0;
        #1 checks++;
        if (di0[4] !== 1'b0) begin errors++; $display("FAIL latch_release got %b exp 0", di0[4]); end
    endtask

    task automatic test_reset_async;
        at_neg; d0 = 1'b1; d1 = 1'b1; oe = 1'b1; ce = 1'b1;
        at_pos; at_neg; at_pos;
        #1 rst_n = 1'b0;
        #1 checks += 4;
        if (di1[2] !== 1'b0) begin errors++; $display("FAIL async_ddr_din1 got %b exp 0", di1[2]); end
        if (p_ddr !== 1'b0) begin errors++; $display("FAIL async_ddr_pin got %b exp 0", p_ddr); end
        if (p_reg !== 1'b0) begin errors++; $display("FAIL async_reg_pin got %b exp 0", p_reg); end
        if (p_oer !== 1'b1) begin errors++; $display("FAIL async_oer_released got %b exp 1", p_oer); end
        #1 rst_n = 1'b1; ce = 1'b0;
        at_neg; checks++;
        if (p_ddr !== 1'b0) begin errors++; $display("FAIL ce_hold_ddr_low got %b exp 0", p_ddr); end
        at_pos; checks += 3;
        if (p_ddr !== 1'b0) begin errors++; $display("FAIL ce_hold_ddr_high got %b exp 0", p_ddr); end
        if (p_reg !== 1'b0) begin errors++; $display("FAIL ce_hold_reg got %b exp 0", p_reg); end
        if (p_oer !== 1'b1) begin errors++; $display("FAIL ce_hold_oe got %b exp 1", p_oer); end
        at_neg; ce = 1'b1;
        at_pos; checks++;
        if (p_reg !== 1'b1) begin errors++; $display("FAIL ce_resume_reg got %b exp 1", p_reg); end
    endtask

    task automatic test_random;
        logic m_out = 1'b0, m_rin = 1'b0, m_q1 = 1'b0, m_reg_q1 = 1'b0, m_oe = 1'b0;
        logic m_lat_q1 = 1'b0, m_held_lat = 1'b0, m_rl_q0 = 1'b0, m_held_rl = 1'b0;
        logic e;
        at_pos;
        ce = 1'b1; latch = 1'b0; oe = 1'b0; d0 = 1'b0; d1 = 1'b0;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            at_neg;
            if (ce) begin m_q1 = d1; m_lat_q1 = lat_v; m_reg_q1 = m_out; end
            checks += 3;
            if (p_ddr !== m_q1) begin errors++; $display("FAIL rnd_ddr_low[%0d] got %b exp %b", i, p_ddr, m_q1); end
            if (di1[4] !== m_lat_q1) begin errors++; $display("FAIL rnd_lat_din1[%0d] got %b exp %b", i, di1[4], m_lat_q1); end
            if (di1[1] !== m_reg_q1) begin errors++; $display("FAIL rnd_reg_din1[%0d] got %b exp %b", i, di1[1], m_reg_q1); end
            ce = $urandom_range(0, 3) != 0;
            {d0, d1, oe, latch, tri_v, lat_v, rl_v} = 7'($urandom);
            #1 checks += 6;
            e = oe ? d0 : tri_v;
            if (p_tri !== e) begin errors++; $display("FAIL rnd_tri_pin[%0d] got %b exp %b", i, p_tri, e); end
            if (di0[0] !== e) begin errors++; $display("FAIL rnd_tri_din0[%0d] got %b exp %b", i, di0[0], e); end
            e = m_oe ? d0 : 1'b1;
            if (p_oer !== e) begin errors++; $display("FAIL rnd_oer_pin[%0d] got %b exp %b", i, p_oer, e); end
            if (di0[3] !== e) begin errors++; $display("FAIL rnd_oer_din0[%0d] got %b exp %b", i, di0[3], e); end
            e = latch ? m_held_lat : lat_v;
            if (di0[4] !== e) begin errors++; $display("FAIL rnd_lat_din0[%0d] got %b exp %b", i, di0[4], e); end
            e = latch ? m_held_rl : m_rl_q0;
            if (di0[6] !== e) begin errors++; $display("FAIL rnd_rl_din0[%0d] got %b exp %b", i, di0[6], e); end
            at_pos;
            if (ce) begin
                m_rin = m_out; m_out = d0; m_oe = oe; m_rl_q0 = rl_v;
                if (!latch) begin m_held_lat = lat_v; m_held_rl = rl_v; end
            end
            checks += 4;
            if (p_reg !== m_out) begin errors++; $display("FAIL rnd_reg_pin[%0d] got %b exp %b", i, p_reg, m_out); end
            if (di0[1] !== m_rin) begin errors++; $display("FAIL rnd_reg_din0[%0d] got %b exp %b", i, di0[1], m_rin); end
            if (p_ddr !== m_out) begin errors++; $display("FAIL rnd_ddr_high[%0d] got %b exp %b", i, p_ddr, m_out); end
            e = latch ? m_held_rl : m_rl_q0;
            if (di0[6] !== e) begin errors++; $display("FAIL rnd_rl_din0_edge[%0d] got %b exp %b", i, di0[6], e); end
        end
    endtask

    initial begin
        test_reset;
        test_comb_tristate;
        test_registered;
        test_ddr;
        test_oe_registered;
        test_latch;
        test_reset_async;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end
endmodule
